// File: rtl/sram_dp_model.sv
// Simple-dual-port SRAM model: byte-lane write port, pipelined read port, built-in array clear engine.
// Latency: read data and rd_valid RD_LAT cycles after the accepting edge; writes visible to the next read.
// Backpressure: none on the ports; while busy (clear sweep) all write/read/clear requests are dropped.
module sram_dp_model #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 65536,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clr_req,
  input  logic [DATA_W-1:0]   clr_val,
  output logic                busy,
  output logic                addr_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   clr_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                idle_ok;
  logic                wr_ok;
  logic                rd_ok;
  logic                wr_acc;
  logic                rd_acc;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    clr_idx;
  logic [DATA_W-1:0]   rd_old;
  logic [DATA_W-1:0]   rd_new;
  logic [DATA_W-1:0]   rd_word;

  logic [RD_LAT-1:0]   pv;
  logic [DATA_W-1:0]   pd [RD_LAT];

  // A clear request wins its own cycle, so ports only act in IDLE without clr_req
  assign idle_ok = (state == IDLE) && !clr_req;
  assign wr_ok   = {1'b0, wr_addr} < DEPTH_X;
  assign rd_ok   = {1'b0, rd_addr} < DEPTH_X;
  assign wr_acc  = wr_en && idle_ok;
  assign rd_acc  = rd_en && idle_ok;
  assign wr_idx  = wr_addr[IDX_W-1:0];
  assign rd_idx  = rd_addr[IDX_W-1:0];
  assign clr_idx = cnt[IDX_W-1:0];

  // Read sample: old word, or old word merged with a same-cycle write to the same address
  always_comb begin
    rd_old = rd_ok ? mem[rd_idx] : '0;
    rd_new = rd_old;
    if (wr_acc && wr_ok && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_new[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
    rd_word = (RDW_MODE != 0) ? rd_new : rd_old;
  end

  // Array update: sweep owns the array while clearing, otherwise byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= clr_q;
      end else if (wr_acc && wr_ok) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Clear engine: latch fill value, sweep every address once, then release the ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      clr_q <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
            clr_q <= clr_val;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Read pipeline: data stages only load behind a valid so rd_data holds between results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc) pd[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  // Range error: one pulse per edge no matter how many accepted accesses were out of range
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= (wr_acc && !wr_ok) || (rd_acc && !rd_ok);
    end
  end

  assign rd_valid = pv[RD_LAT-1];
  assign rd_data  = pd[RD_LAT-1];

endmodule

// File: tb/tb_sram_dp_model.sv
// Bench for sram_dp_model: two instances share stimulus, one RD_LAT=1/old-data, one RD_LAT=3/new-data.
// Expected outputs come from a word-array model plus per-instance queues of scheduled read results.
module tb_sram_dp_model;
  localparam int DW = 24;
  localparam int AW = 5;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [2:0]    wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          clr_req = 1'b0;
  logic [DW-1:0] clr_val = '0;

  logic [DW-1:0] a_rd_data, b_rd_data;
  logic          a_rd_valid, b_rd_valid, a_busy, b_busy, a_addr_err, b_addr_err;

  always #5 clk = ~clk;

  sram_dp_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RD_LAT(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .clr_req(clr_req), .clr_val(clr_val), .busy(a_busy), .addr_err(a_addr_err));

  sram_dp_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RD_LAT(3), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .clr_req(clr_req), .clr_val(clr_val), .busy(b_busy), .addr_err(b_addr_err));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: plain word array, clear progress, and scheduled read results per instance
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } res_t;

  logic [DW-1:0] mm [DP];
  logic          m_busy = 1'b0;
  int            m_pos  = 0;
  logic [DW-1:0] m_cv   = '0;
  logic          m_err  = 1'b0;
  res_t          qa[$];
  res_t          qb[$];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;

  task automatic model_edge();
    logic [DW-1:0] d_old, d_new;
    logic          rok, wok;
    cyc++;
    m_err = 1'b0;
    if (!m_busy && clr_req) begin
      m_busy = 1'b1;
      m_pos  = 0;
      m_cv   = clr_val;
    end else if (m_busy) begin
      mm[m_pos] = m_cv;
      m_pos++;
      if (m_pos == DP) m_busy = 1'b0;
    end else begin
      rok   = (int'(rd_addr) < DP);
      wok   = (int'(wr_addr) < DP);
      d_old = rok ? mm[rd_addr[3:0]] : '0;
      if (wr_en && wok) begin
        for (int i = 0; i < 3; i++)
          if (wr_be[i]) mm[wr_addr[3:0]][8*i +: 8] = wr_data[8*i +: 8];
      end
      d_new = rok ? mm[rd_addr[3:0]] : '0;
      if (rd_en) begin
        qa.push_back('{cyc, d_old});
        qb.push_back('{cyc + 2, d_new});
      end
      m_err = (rd_en && !rok) || (wr_en && !wok);
    end
  endtask

  task automatic check_out();
    logic ev;
    ev = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      ev = 1'b1; last_a = qa[0].d; qa.delete(0);
    end
    chk("a_valid", 32'(a_rd_valid), 32'(ev));
    chk("a_data", 32'(a_rd_data), 32'(last_a));
    ev = 1'b0;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      ev = 1'b1; last_b = qb[0].d; qb.delete(0);
    end
    chk("b_valid", 32'(b_rd_valid), 32'(ev));
    chk("b_data", 32'(b_rd_data), 32'(last_b));
    chk("a_busy", 32'(a_busy), 32'(m_busy));
    chk("b_busy", 32'(b_busy), 32'(m_busy));
    chk("a_err", 32'(a_addr_err), 32'(m_err));
    chk("b_err", 32'(b_addr_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [2:0] be, input logic re, input logic [AW-1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clr_req = 1'b0;
  endtask

  task automatic nop(input int n);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset: outputs must drop before any clock edge, then stay 0 through one edge
  task automatic do_reset();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    #1;
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0; m_busy = 1'b0; m_pos = 0; m_err = 1'b0;
    check_out();
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int bcnt;

  initial begin
    @(negedge clk);
    do_reset();

    // Clear to ABCDEF; a write/read to address 3 during the sweep must be dropped
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    clr_req = 1'b1; clr_val = 24'hABCDEF;
    step();
    bcnt = int'(a_busy);
    drive(1'b1, 5'd3, 24'h000111, 3'b111, 1'b1, 5'd3);
    for (int i = 0; i < 15; i++) begin step(); bcnt += int'(a_busy); end
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin step(); bcnt += int'(a_busy); end
    chk("busy_len", 32'(bcnt), 32'd16);
    for (int i = 0; i < DP; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
      step();
      chk("clr_rd", 32'(a_rd_data), 32'h00ABCDEF);
    end
    nop(3);

    // Reset after 8 sweep writes: low half cleared, high half keeps ABCDEF
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    clr_req = 1'b1; clr_val = 24'h5A5A5A;
    step();
    nop(8);
    do_reset();
    chk("rst_busy", 32'(a_busy), 32'd0);
    for (int i = 0; i < DP; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
      step();
      chk("part_clr", 32'(a_rd_data), (i < 8) ? 32'h005A5A5A : 32'h00ABCDEF);
    end
    nop(3);

    // Basic write then read
    drive(1'b1, 5'd5, 24'h123456, 3'b111, 1'b0, '0); step();
    drive(1'b0, '0, '0, '0, 1'b1, 5'd5); step();
    chk("basic_v", 32'(a_rd_valid), 32'd1);
    chk("basic_d", 32'(a_rd_data), 32'h00123456);
    nop(1);
    chk("basic_pulse", 32'(a_rd_valid), 32'd0);
    nop(3);

    // Byte lanes
    drive(1'b1, 5'd7, 24'hAABBCC, 3'b111, 1'b0, '0); step();
    drive(1'b1, 5'd7, 24'h112233, 3'b010, 1'b0, '0); step();
    drive(1'b0, '0, '0, '0, 1'b1, 5'd7); step();
    chk("lanes", 32'(a_rd_data), 32'h00AA22CC);
    nop(3);

    // Read-during-write to the same address
    drive(1'b1, 5'd9, 24'h000001, 3'b111, 1'b0, '0); step();
    drive(1'b1, 5'd9, 24'h0000FF, 3'b111, 1'b1, 5'd9); step();
    chk("rdw_old", 32'(a_rd_data), 32'h00000001);
    nop(2);
    chk("rdw_new", 32'(b_rd_data), 32'h000000FF);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd9); step();
    chk("rdw_after", 32'(a_rd_data), 32'h000000FF);
    nop(3);

    // Latency 3 and back-to-back throughput on instance b
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), 24'(32'h10 + i), 3'b111, 1'b0, '0); step();
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b0, '0, '0, '0, 1'b1, AW'(k));
      else       drive(1'b0, '0, '0, '0, 1'b0, '0);
      step();
      chk("lat_v", 32'(b_rd_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) chk("lat_d", 32'(b_rd_data), 32'h10 + 32'(k - 2));
    end
    nop(3);

    // Out-of-range accesses
    drive(1'b1, 5'd20, 24'h777777, 3'b111, 1'b0, '0); step();
    chk("err_wr", 32'(a_addr_err), 32'd1);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd20); step();
    chk("err_rd_v", 32'(a_rd_valid), 32'd1);
    chk("err_rd_d", 32'(a_rd_data), 32'd0);
    chk("err_rd_e", 32'(a_addr_err), 32'd1);
    drive(1'b1, 5'd31, 24'h111111, 3'b111, 1'b1, 5'd17); step();
    drive(1'b0, '0, '0, '0, 1'b1, 5'd4); step();
    chk("err_one_pulse", 32'(a_addr_err), 32'd0);
    chk("err_no_write", 32'(a_rd_data), 32'h005A5A5A);
    nop(3);

    // Randomized traffic with occasional clears
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), 24'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
      if ($urandom_range(0, 63) == 0) begin
        clr_req = 1'b1; clr_val = 24'($urandom);
      end
      step();
    end
    nop(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_dp_model.md
# sram_dp_model

Parametrised simple-dual-port SRAM behavioural model: one write port with byte-lane enables and one read port with configurable read latency and a valid flag. It also has a built-in clear engine that sweeps the whole array to a programmable value. It replaces the single-port 24-bit frame-buffer model in the image-rotation datapath, where the source read and the rotated write run concurrently.

## Interface

Parameters:
- DATA_W, 24: word width. Must be a multiple of 8.
- ADDR_W, 16: address width.
- DEPTH, 65536: number of words. Must satisfy DEPTH ≤ 2**ADDR_W.
- RD_LAT, 1: read latency in cycles. Legal range 1..4.
- RDW_MODE, 0: same-address read-during-write result. 0 returns old data; 1 returns new (merged) data.

Ports:
- clk, input, 1: single clock. All activity is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: write request.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, DATA_W: write data.
- wr_be, input, DATA_W/8: byte-lane enables. Bit i covers wr_data[8i+7:8i].
- rd_en, input, 1: read request.
- rd_addr, input, ADDR_W: read address.
- rd_data, output, DATA_W: read data. Held between reads.
- rd_valid, output, 1: one-cycle pulse when rd_data carries a new result.
- clr_req, input, 1: start an array clear. Sampled only when busy=0.
- clr_val, input, DATA_W: fill value, latched with clr_req.
- busy, output, 1: high while a clear is in progress.
- addr_err, output, 1: one-cycle pulse for any accepted access with an address ≥ DEPTH.

## Operation

- Storage is DEPTH×DATA_W. Array contents are not affected by rst; contents after power-up are undefined.
- Write: when wr_en=1 and busy=0, each lane with wr_be[i]=1 is updated at the clock edge. Other lanes keep their value. wr_be=0 is a legal no-op.
- Read: when rd_en=1 and busy=0, the array is sampled at the edge and enters a RD_LAT-deep pipeline of {valid, data}.
- Read and write are independent. Both may be accepted in the same cycle.
- Same address in the same cycle: with RDW_MODE=0 the read returns the pre-write word. With RDW_MODE=1 it returns the word after the byte-enable merge.
- Out-of-range address (≥ DEPTH):
  - Write: dropped, addr_err pulses.
  - Read: still produces rd_valid, with rd_data=0, and addr_err pulses.
  - A read error and a write error in the same cycle produce a single addr_err pulse.
- Clear FSM states are IDLE and CLEAR.
  - IDLE→CLEAR: on clr_req=1 while busy=0. clr_val is latched and the sweep address counter is set to 0.
  - In the request cycle, clr_req has priority: wr_en and rd_en are ignored and addr_err stays 0.
  - CLEAR: writes the latched value to counter address every cycle, with all lanes enabled, then increments the counter.
  - CLEAR→IDLE: after writing address DEPTH-1.
  - While in CLEAR: wr_en, rd_en and clr_req are ignored. No new rd_valid is issued, but reads already in the pipeline drain normally.
- rst at any time (including mid-clear):
  - FSM goes to IDLE and the counter to 0.
  - The pipeline is flushed.
  - Partially cleared contents are kept as they are.

## Timing

- Reset values: rd_data=0, rd_valid=0, busy=0, addr_err=0.
- Read accepted at edge N: rd_valid=1 and rd_data are valid in the cycle after edge N+RD_LAT-1. For RD_LAT=1 they are visible right after edge N.
- Back-to-back reads give back-to-back rd_valid pulses, one read per cycle.
- Write at edge N is visible to a read accepted at edge N+1 or later, in both modes.
- addr_err is registered and asserted the cycle after the offending edge.
- busy is registered high after the edge that samples clr_req. It stays high for exactly DEPTH cycles, then falls.
- A read accepted at edge N+DEPTH+1 after a clear request at edge N returns clr_val.

## Test plan

- Reset and basic access, RD_LAT=1:
  - With rst held, all outputs are 0.
  - Write 0x123456 to address 5 with wr_be=3'b111, then read 5 → rd_data=0x123456 with a one-cycle rd_valid one cycle after the read edge.
- Byte lanes: address 7 holds 0xAABBCC. Write 0x112233 with wr_be=3'b010, then read 7 → 0xAA22CC.
- Read-during-write: address 9 holds 0x000001. In one cycle, write 0x0000FF to 9 and read 9.
  - RDW_MODE=0 → 0x000001.
  - RDW_MODE=1 → 0x0000FF.
  - A later read returns 0x0000FF in both modes.
- Latency and throughput: RD_LAT=3, four consecutive reads of addresses 0..3 preloaded with 0x10..0x13 → four consecutive rd_valid pulses starting 3 cycles after the first read edge, with data 0x10, 0x11, 0x12, 0x13 in order.
- Clear: DEPTH=16, clr_req with clr_val=0xABCDEF.
  - busy is high for exactly 16 cycles.
  - A wr_en to address 3 during busy is ignored.
  - Reads of 0..15 afterwards all return 0xABCDEF.
  - rst pulsed at clear cycle 8 → busy=0 immediately. Addresses 0..7 are cleared (8 writes completed before rst); higher addresses keep their old data.
- Range error: DEPTH=16, ADDR_W=5. Write to 20 → addr_err pulse and no array change. Read 20 → rd_valid with rd_data=0 plus an addr_err pulse.
